// File: rtl/fft_pkg.sv
// Shared FFT post-processing definitions: magnitude-squared width helper and frame FSM states.
// Also used by the downstream frequency interpolator.
package fft_pkg;

    function automatic int mw(input int dw);
        return 2 * dw + 1;
    endfunction

    localparam int DW_DEF = 16;
    localparam int IW_DEF = 10;
    localparam int MW_DEF = mw(DW_DEF);

    typedef logic [MW_DEF-1:0] mag_def_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } frame_state_t;

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage front end: S1 registers the beat, S2 forms re^2 + im^2 and carries the
// valid/last/idx/eligible sideband alongside the magnitude.
module fft_mag_sq
    import fft_pkg::*;
#(
    parameter int DW   = 16,
    parameter int IW   = 10,
    parameter int SKIP = 1,
    parameter int MW   = mw(DW)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 valid,
    input  logic                 last,
    input  logic [IW-1:0]        idx,
    input  logic signed [DW-1:0] re,
    input  logic signed [DW-1:0] im,
    output logic                 mag_valid,
    output logic                 mag_last,
    output logic                 mag_elig,
    output logic [IW-1:0]        mag_idx,
    output logic signed [DW-1:0] mag_re,
    output logic signed [DW-1:0] mag_im,
    output logic [MW-1:0]        mag,
    output logic                 busy
);

    // One extra bit so SKIP = 2**IW (exclude everything) is representable.
    localparam logic [IW:0] SKIP_V = (IW + 1)'(SKIP);

    logic                 s1_valid;
    logic                 s1_last;
    logic                 s1_elig;
    logic [IW-1:0]        s1_idx;
    logic signed [DW-1:0] s1_re;
    logic signed [DW-1:0] s1_im;
    logic signed [2*DW-1:0] re_sq;
    logic signed [2*DW-1:0] im_sq;
    logic [MW-1:0]        mag_sum;

    assign re_sq   = s1_re * s1_re;
    assign im_sq   = s1_im * s1_im;
    assign mag_sum = MW'($unsigned(re_sq)) + MW'($unsigned(im_sq));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_elig   <= 1'b0;
            s1_idx    <= '0;
            s1_re     <= '0;
            s1_im     <= '0;
            mag_valid <= 1'b0;
            mag_last  <= 1'b0;
            mag_elig  <= 1'b0;
            mag_idx   <= '0;
            mag_re    <= '0;
            mag_im    <= '0;
            mag       <= '0;
        end else begin
            if (clr) begin
                s1_valid  <= 1'b0;
                mag_valid <= 1'b0;
            end else begin
                s1_valid  <= valid;
                mag_valid <= s1_valid;
            end
            if (valid) begin
                s1_last <= last;
                s1_elig <= ({1'b0, idx} >= SKIP_V);
                s1_idx  <= idx;
                s1_re   <= re;
                s1_im   <= im;
            end
            if (s1_valid) begin
                mag_last <= s1_last;
                mag_elig <= s1_elig;
                mag_idx  <= s1_idx;
                mag_re   <= s1_re;
                mag_im   <= s1_im;
                mag      <= mag_sum;
            end
        end
    end

    assign busy = s1_valid | mag_valid;

endmodule

// File: rtl/fft_peak_search.sv
// Spectral peak detector: S3 compare/update with neighbour magnitudes, frame FSM and result outputs.
//   state   | meaning
//   IDLE    | no frame open; next S3 beat starts a fresh frame
//   ACC     | frame open, accumulating the running max
module fft_peak_search
    import fft_pkg::*;
#(
    parameter int DW   = 16,
    parameter int IW   = 10,
    parameter int SKIP = 1,
    parameter int MW   = mw(DW)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 opd_o,
    input  logic                 soud_o,
    input  logic [IW-1:0]        idx,
    input  logic signed [DW-1:0] xk_re,
    input  logic signed [DW-1:0] xk_im,
    output logic                 peak_valid,
    output logic [IW-1:0]        peak_idx,
    output logic signed [DW-1:0] peak_re,
    output logic signed [DW-1:0] peak_im,
    output logic [MW-1:0]        peak_mag,
    output logic [MW-1:0]        left_mag,
    output logic [MW-1:0]        right_mag,
    output logic                 no_peak,
    output logic                 busy
);

    logic                 s3_valid, s3_last, s3_elig, pipe_busy;
    logic [IW-1:0]        s3_idx;
    logic signed [DW-1:0] s3_re, s3_im;
    logic [MW-1:0]        s3_mag;

    fft_mag_sq #(.DW(DW), .IW(IW), .SKIP(SKIP), .MW(MW)) u_mag_sq (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .valid     (opd_o),
        .last      (soud_o),
        .idx       (idx),
        .re        (xk_re),
        .im        (xk_im),
        .mag_valid (s3_valid),
        .mag_last  (s3_last),
        .mag_elig  (s3_elig),
        .mag_idx   (s3_idx),
        .mag_re    (s3_re),
        .mag_im    (s3_im),
        .mag       (s3_mag),
        .busy      (pipe_busy)
    );

    frame_state_t         state;
    logic                 found, pend, done;
    logic [MW-1:0]        max_mag, max_left, max_right, prev_mag;
    logic [IW-1:0]        max_idx;
    logic signed [DW-1:0] max_re, max_im;

    logic                 res_no_peak;
    logic [IW-1:0]        res_idx;
    logic signed [DW-1:0] res_re, res_im;
    logic [MW-1:0]        res_mag, res_left, res_right;

    logic                 first, n_found, n_pend;
    logic [MW-1:0]        n_mag, n_left, n_right;
    logic [IW-1:0]        n_idx;
    logic signed [DW-1:0] n_re, n_im;

    assign first = (state == ST_IDLE);

    // Accumulators are masked on the first beat so a new frame never sees the previous one.
    always_comb begin
        n_found = found & ~first;
        n_pend  = pend & ~first;
        n_mag   = first ? '0 : max_mag;
        n_idx   = first ? '0 : max_idx;
        n_re    = first ? '0 : max_re;
        n_im    = first ? '0 : max_im;
        n_left  = first ? '0 : max_left;
        n_right = first ? '0 : max_right;
        if (s3_elig && (!n_found || s3_mag > n_mag)) begin
            n_found = 1'b1;
            n_mag   = s3_mag;
            n_idx   = s3_idx;
            n_re    = s3_re;
            n_im    = s3_im;
            n_left  = first ? '0 : prev_mag;
            n_right = '0;
            n_pend  = 1'b1;
        end else if (n_pend) begin
            n_right = s3_mag;
            n_pend  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            found       <= 1'b0;
            pend        <= 1'b0;
            done        <= 1'b0;
            max_mag     <= '0;
            max_idx     <= '0;
            max_re      <= '0;
            max_im      <= '0;
            max_left    <= '0;
            max_right   <= '0;
            prev_mag    <= '0;
            res_no_peak <= 1'b0;
            res_idx     <= '0;
            res_re      <= '0;
            res_im      <= '0;
            res_mag     <= '0;
            res_left    <= '0;
            res_right   <= '0;
            peak_valid  <= 1'b0;
            no_peak     <= 1'b0;
            peak_idx    <= '0;
            peak_re     <= '0;
            peak_im     <= '0;
            peak_mag    <= '0;
            left_mag    <= '0;
            right_mag   <= '0;
        end else if (clr) begin
            state      <= ST_IDLE;
            found      <= 1'b0;
            pend       <= 1'b0;
            done       <= 1'b0;
            peak_valid <= 1'b0;
            max_mag    <= '0;
            max_idx    <= '0;
            max_re     <= '0;
            max_im     <= '0;
            max_left   <= '0;
            max_right  <= '0;
        end else begin
            done       <= 1'b0;
            peak_valid <= done;
            // Outputs load together with the strobe so they stay stable for the whole pulse.
            if (done) begin
                no_peak   <= res_no_peak;
                peak_idx  <= res_idx;
                peak_re   <= res_re;
                peak_im   <= res_im;
                peak_mag  <= res_mag;
                left_mag  <= res_left;
                right_mag <= res_right;
            end
            if (s3_valid) begin
                prev_mag <= s3_mag;
                if (s3_last) begin
                    state       <= ST_IDLE;
                    done        <= 1'b1;
                    found       <= 1'b0;
                    pend        <= 1'b0;
                    max_mag     <= '0;
                    max_idx     <= '0;
                    max_re      <= '0;
                    max_im      <= '0;
                    max_left    <= '0;
                    max_right   <= '0;
                    res_no_peak <= ~n_found;
                    res_idx     <= n_found ? n_idx : '0;
                    res_re      <= n_found ? n_re : '0;
                    res_im      <= n_found ? n_im : '0;
                    res_mag     <= n_found ? n_mag : '0;
                    res_left    <= n_found ? n_left : '0;
                    res_right   <= n_found ? n_right : '0;
                end else begin
                    state     <= ST_ACC;
                    found     <= n_found;
                    pend      <= n_pend;
                    max_mag   <= n_mag;
                    max_idx   <= n_idx;
                    max_re    <= n_re;
                    max_im    <= n_im;
                    max_left  <= n_left;
                    max_right <= n_right;
                end
            end
        end
    end

    assign busy = (state == ST_ACC) | pipe_busy;

endmodule

// File: tb/tb_fft_peak_search.sv
// Directed bench for fft_peak_search: one DUT with SKIP=1 and one with SKIP=4 on shared stimulus.
module tb_fft_peak_search;

    localparam int DW = 16;
    localparam int IW = 10;
    localparam int MW = 2 * DW + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 clr, opd_o, soud_o;
    logic [IW-1:0]        idx;
    logic signed [DW-1:0] xk_re, xk_im;

    logic                 pv_a, np_a, busy_a, pv_b, np_b, busy_b;
    logic [IW-1:0]        pidx_a, pidx_b;
    logic signed [DW-1:0] pre_a, pim_a, pre_b, pim_b;
    logic [MW-1:0]        pmag_a, lmag_a, rmag_a, pmag_b, lmag_b, rmag_b;

    typedef struct {
        logic [IW-1:0]        idx;
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        logic [MW-1:0]        mag;
        logic [MW-1:0]        left;
        logic [MW-1:0]        right;
        logic                 np;
    } res_t;

    res_t qa[$];
    res_t qb[$];
    res_t mon_a, mon_b, r;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    fft_peak_search #(.DW(DW), .IW(IW), .SKIP(1)) u_dut (
        .clk(clk), .rst(rst_n), .clr(clr), .opd_o(opd_o), .soud_o(soud_o), .idx(idx),
        .xk_re(xk_re), .xk_im(xk_im), .peak_valid(pv_a), .peak_idx(pidx_a), .peak_re(pre_a),
        .peak_im(pim_a), .peak_mag(pmag_a), .left_mag(lmag_a), .right_mag(rmag_a),
        .no_peak(np_a), .busy(busy_a)
    );

    fft_peak_search #(.DW(DW), .IW(IW), .SKIP(4)) u_dut4 (
        .clk(clk), .rst(rst_n), .clr(clr), .opd_o(opd_o), .soud_o(soud_o), .idx(idx),
        .xk_re(xk_re), .xk_im(xk_im), .peak_valid(pv_b), .peak_idx(pidx_b), .peak_re(pre_b),
        .peak_im(pim_b), .peak_mag(pmag_b), .left_mag(lmag_b), .right_mag(rmag_b),
        .no_peak(np_b), .busy(busy_b)
    );

    always @(posedge clk) begin
        #1;
        if (pv_a === 1'b1) begin
            mon_a.idx = pidx_a; mon_a.re = pre_a; mon_a.im = pim_a; mon_a.mag = pmag_a;
            mon_a.left = lmag_a; mon_a.right = rmag_a; mon_a.np = np_a;
            qa.push_back(mon_a);
        end
        if (pv_b === 1'b1) begin
            mon_b.idx = pidx_b; mon_b.re = pre_b; mon_b.im = pim_b; mon_b.mag = pmag_b;
            mon_b.left = lmag_b; mon_b.right = rmag_b; mon_b.np = np_b;
            qb.push_back(mon_b);
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input int i, input int re, input int im, input bit last);
        @(negedge clk);
        opd_o  = 1'b1;
        soud_o = last;
        idx    = IW'(i);
        xk_re  = DW'(re);
        xk_im  = DW'(im);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            opd_o  = 1'b0;
            soud_o = 1'b0;
            clr    = 1'b0;
        end
    endtask

    task automatic wait_q(input string tag, input bit use_b, input int n);
        int k = 0;
        while ((use_b ? qb.size() : qa.size()) < n && k < 40) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk({tag, "_arrived"}, longint'((use_b ? qb.size() : qa.size()) >= n), 1);
    endtask

    task automatic pop(input bit use_b, output res_t o);
        o = '{default: '0};
        if (use_b && qb.size() > 0) o = qb.pop_front();
        else if (!use_b && qa.size() > 0) o = qa.pop_front();
    endtask

    task automatic chk_res(input string tag, input res_t x, input int e_idx, input int e_re,
                           input int e_im, input longint e_mag, input longint e_left,
                           input longint e_right, input bit e_np);
        chk({tag, "_idx"}, x.idx, e_idx);
        chk({tag, "_re"}, x.re, e_re);
        chk({tag, "_im"}, x.im, e_im);
        chk({tag, "_mag"}, x.mag, e_mag);
        chk({tag, "_left"}, x.left, e_left);
        chk({tag, "_right"}, x.right, e_right);
        chk({tag, "_nopeak"}, x.np, e_np);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; opd_o = 1'b0; soud_o = 1'b0;
        idx = '0; xk_re = '0; xk_im = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pv", pv_a, 0);
        chk("rst_nopeak", np_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_idx", pidx_a, 0);
        chk("rst_mag", pmag_a, 0);
        chk("rst_left", lmag_a, 0);
        chk("rst_right", rmag_a, 0);
        chk("rst_re", pre_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        chk("idle_no_pulse", qa.size() + qb.size(), 0);
        chk("idle_busy", busy_a, 0);

        // Frame A: tie at bins 3/4, large but excluded DC bin
        beat(0, 1000, 0, 0);
        @(posedge clk); #1;
        chk("a_busy", busy_a, 1);
        beat(1, 1, 1, 0); beat(2, 1, 1, 0); beat(3, 30, 40, 0); beat(4, -50, 0, 0);
        beat(5, 1, 1, 0); beat(6, 1, 1, 0); beat(7, 1, 1, 1);
        idle(1);
        wait_q("a", 0, 1);
        pop(0, r);
        chk_res("a", r, 3, 30, 40, 2500, 2, 2500, 0);
        wait_q("a4", 1, 1);
        pop(1, r);
        chk_res("a4", r, 4, -50, 0, 2500, 2500, 2, 0);

        // Frame B: peak on the last beat, with latency check
        idle(2);
        beat(0, 1000, 0, 0); beat(1, 1, 1, 0); beat(2, 1, 1, 0); beat(3, 30, 40, 0);
        beat(4, -50, 0, 0); beat(5, 1, 1, 0); beat(6, 1, 1, 0); beat(7, 100, -100, 1);
        @(negedge clk);
        opd_o = 1'b0; soud_o = 1'b0;
        @(posedge clk); #1;
        chk("b_lat_t1", pv_a, 0);
        @(posedge clk); #1;
        chk("b_lat_t2", pv_a, 0);
        @(posedge clk); #1;
        chk("b_lat_t3", pv_a, 1);
        @(posedge clk); #1;
        chk("b_lat_t4", pv_a, 0);
        wait_q("b", 0, 1);
        pop(0, r);
        chk_res("b", r, 7, 100, -100, 20000, 2, 0, 0);
        qb.delete();

        // Frames C1/C2: gaps in the first, second follows with no bubble
        idle(2);
        beat(0, 3, 4, 0); idle(1); beat(1, 0, 2, 0); idle(1); beat(2, 10, 0, 0); idle(1);
        beat(3, 1, 0, 1);
        beat(1, 20, 0, 0); beat(2, 5, 5, 0); beat(3, 2, 0, 0); beat(4, 6, 8, 1);
        idle(1);
        wait_q("c", 0, 2);
        pop(0, r);
        chk_res("c1", r, 2, 10, 0, 100, 4, 1, 0);
        pop(0, r);
        chk_res("c2", r, 1, 20, 0, 400, 0, 50, 0);
        qb.delete();

        // Frame D: nothing eligible for SKIP=4
        idle(2);
        beat(0, 7, 0, 0); beat(1, 1, 2, 0); beat(2, 3, 3, 0); beat(3, 0, 5, 1);
        idle(1);
        wait_q("d4", 1, 1);
        pop(1, r);
        chk_res("d4", r, 0, 0, 0, 0, 0, 0, 1);
        wait_q("d", 0, 1);
        pop(0, r);
        chk_res("d", r, 3, 0, 5, 25, 18, 0, 0);

        // Frame E: clr mid-frame (with a beat in the same cycle), then a fresh frame
        idle(2);
        beat(0, 1, 1, 0); beat(1, 500, 500, 0); beat(2, 600, 600, 1);
        clr = 1'b1;
        idle(8);
        chk("clr_no_pulse", qa.size() + qb.size(), 0);
        chk("clr_busy", busy_a, 0);
        chk("clr_hold_mag", pmag_a, 25);
        beat(0, 1, 0, 0); beat(1, 2, 0, 0); beat(2, 0, 9, 0); beat(3, 4, 4, 1);
        idle(1);
        wait_q("e", 0, 1);
        pop(0, r);
        chk_res("e", r, 2, 0, 9, 81, 4, 32, 0);
        qb.delete();

        // Frame F: async reset mid-frame, then the same fresh frame
        idle(2);
        beat(0, 1, 1, 0); beat(1, 700, 0, 0);
        @(negedge clk);
        opd_o = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("arst_mag", pmag_a, 0);
        chk("arst_busy", busy_a, 0);
        rst_n = 1'b1;
        idle(8);
        chk("arst_no_pulse", qa.size() + qb.size(), 0);
        beat(0, 1, 0, 0); beat(1, 2, 0, 0); beat(2, 0, 9, 0); beat(3, 4, 4, 1);
        idle(1);
        wait_q("f", 0, 1);
        pop(0, r);
        chk_res("f", r, 2, 0, 9, 81, 4, 32, 0);

        idle(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
